sensirion_frame_decoder: RTL and testbench

//   Parametrised byte-stream decoder for Sensirion-style I2C read frames: NUM_WORDS groups of {MSB, LSB, CRC8}.

---
 rtl/sensirion_pkg.sv | 27 ++
 rtl/sensirion_frame_decoder_crc8_serial.sv | 59 +++++
 rtl/sensirion_frame_decoder.sv | 183 ++++++++++++++++++
 tb/tb_sensirion_frame_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensirion_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : sensirion_pkg                                              |
// | Brief   : Shared FSM encodings, CRC-8 defaults and the single-step   |
// |           CRC helper for the Sensirion frame decoder.                |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sensirion_pkg;

  // Decoder FSM encodings; kept as plain constants for legacy tooling
  localparam logic [2:0] S_MSB   = 3'd0;
  localparam logic [2:0] S_LSB   = 3'd1;
  localparam logic [2:0] S_CRC   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Sensirion CRC-8: x^8+x^5+x^4+1, seeded with all ones per word
  localparam logic [7:0] CRC8_POLY = 8'h31;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // One bit-serial division step of an MSB-first CRC-8
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] poly);
    return crc[7] ? ({crc[6:0], 1'b0} ^ poly) : {crc[6:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensirion_frame_decoder_crc8_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : crc8_serial                                                |
// | Brief   : Bit-serial CRC-8 engine. A byte is folded into the         |
// |           register on load, then eight shift cycles follow.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module crc8_serial
  import sensirion_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_abort,
  input  logic       i_load_init,
  input  logic       i_load_xor,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc,
  output logic       o_done
);

  logic [7:0] r_crc;
  logic [2:0] r_cnt;
  logic       r_busy;

  // Load a byte (fresh seed or running remainder), then divide it out over 8 cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc  <= INIT;
      r_cnt  <= 3'd0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= 3'd0;
      r_busy <= 1'b0;
    end else if (i_load_init) begin
      r_crc  <= INIT ^ i_byte;
      r_cnt  <= 3'd0;
      r_busy <= 1'b1;
    end else if (i_load_xor) begin
      r_crc  <= r_crc ^ i_byte;
      r_cnt  <= 3'd0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_crc <= crc8_step(r_crc, POLY);
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_crc  = r_crc;
  // High during the eighth shift cycle so the caller can leave on that edge
  assign o_done = r_busy & (r_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/sensirion_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sensirion_frame_decoder                                    |
// | Brief   : Decodes NUM_WORDS x {MSB, LSB, CRC8} I2C read frames,      |
// |           latching CRC-clean words and reporting frame status.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sensirion_frame_decoder
  import sensirion_pkg::*;
#(
  parameter int         NUM_WORDS = 2,
  parameter logic [7:0] CRC_POLY  = CRC8_POLY,
  parameter logic [7:0] CRC_INIT  = CRC8_INIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [16*NUM_WORDS-1:0] word_data,
  output logic [NUM_WORDS-1:0]   word_fresh,
  output logic                   frame_done,
  output logic                   frame_crc_ok,
  output logic [7:0]             crc_err_cnt
);

  localparam int              IDXW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NUM_WORDS - 1);

  logic [2:0]             r_state;
  logic [2:0]             r_ret;
  logic [IDXW-1:0]        r_idx;
  logic [7:0]             r_stage_hi;
  logic [7:0]             r_stage_lo;
  logic [16*NUM_WORDS-1:0] r_word_data;
  logic [NUM_WORDS-1:0]   r_fresh_acc;
  logic [NUM_WORDS-1:0]   r_word_fresh;
  logic                   r_frame_bad;
  logic [7:0]             r_err_cnt;

  logic                   w_in_msb;
  logic                   w_in_lsb;
  logic                   w_in_crc;
  logic                   w_in_done;
  logic                   w_accept;
  logic                   w_crc_match;
  logic                   w_crc_done;
  logic                   w_word_bad;
  logic [7:0]             w_crc;
  logic [NUM_WORDS-1:0]   w_idx_onehot;

  assign w_in_msb  = (r_state == S_MSB);
  assign w_in_lsb  = (r_state == S_LSB);
  assign w_in_crc  = (r_state == S_CRC);
  assign w_in_done = (r_state == S_DONE);

  // Abort blocks acceptance combinationally so a byte presented with it is dropped
  assign in_ready     = (w_in_msb | w_in_lsb | w_in_crc) & ~abort;
  assign w_accept     = in_valid & in_ready;
  assign w_crc_match  = (in_data == w_crc);
  assign w_word_bad   = w_accept & w_in_crc & ~w_crc_match;
  assign w_idx_onehot = NUM_WORDS'(1) << r_idx;

  crc8_serial #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_crc8_serial (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_abort     (abort),
    .i_load_init (w_accept & w_in_msb),
    .i_load_xor  (w_accept & w_in_lsb),
    .i_byte      (in_data),
    .o_crc       (w_crc),
    .o_done      (w_crc_done)
  );

  // Frame sequencing: byte position, word index and accumulated frame status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_MSB;
      r_ret       <= S_MSB;
      r_idx       <= '0;
      r_fresh_acc <= '0;
      r_frame_bad <= 1'b0;
    end else if (abort) begin
      r_state     <= S_MSB;
      r_idx       <= '0;
      r_fresh_acc <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      case (r_state)
        S_MSB: begin
          if (w_accept) begin
            r_state <= S_SHIFT;
            r_ret   <= S_LSB;
          end
        end
        S_LSB: begin
          if (w_accept) begin
            r_state <= S_SHIFT;
            r_ret   <= S_CRC;
          end
        end
        S_SHIFT: begin
          if (w_crc_done) begin
            r_state <= r_ret;
          end
        end
        S_CRC: begin
          if (w_accept) begin
            if (w_crc_match) begin
              r_fresh_acc <= r_fresh_acc | w_idx_onehot;
            end else begin
              r_frame_bad <= 1'b1;
            end
            // A bad word does not end the frame; the rest is still decoded
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_MSB;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_MSB;
          r_idx       <= '0;
          r_fresh_acc <= '0;
          r_frame_bad <= 1'b0;
        end
        default: begin
          r_state <= S_MSB;
        end
      endcase
    end
  end

  // Word staging and result registers; results survive abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_hi   <= 8'd0;
      r_stage_lo   <= 8'd0;
      r_word_data  <= '0;
      r_word_fresh <= '0;
    end else begin
      if (w_accept & w_in_msb) begin
        r_stage_hi <= in_data;
      end
      if (w_accept & w_in_lsb) begin
        r_stage_lo <= in_data;
      end
      if (w_accept & w_in_crc & w_crc_match) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (w_idx_onehot[i]) begin
            r_word_data[16*i +: 16] <= {r_stage_hi, r_stage_lo};
          end
        end
      end
      if (w_in_done & ~abort) begin
        r_word_fresh <= r_fresh_acc;
      end
    end
  end

  // Saturating count of words whose CRC byte disagreed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_word_bad && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign word_data    = r_word_data;
  assign word_fresh   = r_word_fresh;
  assign crc_err_cnt  = r_err_cnt;
  assign frame_done   = w_in_done & ~abort;
  assign frame_crc_ok = frame_done & ~r_frame_bad;

endmodule
`default_nettype wire

// File: tb/tb_sensirion_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sensirion_frame_decoder                                 |
// | Brief   : Self-checking bench: frame-level reference model compared  |
// |           every cycle, plus directed literal expectations.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_sensirion_frame_decoder;

  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // two-word instance
  logic        rst_n, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, frame_done, frame_crc_ok;
  logic [31:0] word_data;
  logic [1:0]  word_fresh;
  logic [7:0]  crc_err_cnt;

  // one-word instance
  logic        abort2, in_valid2;
  logic [7:0]  in_data2;
  logic        in_ready2, frame_done2, frame_crc_ok2;
  logic [15:0] word_data2;
  logic [0:0]  word_fresh2;
  logic [7:0]  crc_err_cnt2;

  sensirion_frame_decoder #(.NUM_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .word_data(word_data), .word_fresh(word_fresh),
    .frame_done(frame_done), .frame_crc_ok(frame_crc_ok), .crc_err_cnt(crc_err_cnt)
  );

  sensirion_frame_decoder #(.NUM_WORDS(1)) dut1w (
    .clk(clk), .rst_n(rst_n), .abort(abort2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .word_data(word_data2), .word_fresh(word_fresh2),
    .frame_done(frame_done2), .frame_crc_ok(frame_crc_ok2), .crc_err_cnt(crc_err_cnt2)
  );

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int n_done2  = 0;
  logic last_ok  = 1'b0;
  logic last_ok2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference CRC: feed the 16 data bits MSB first through the polynomial divider
  function automatic logic [7:0] crc_ref(input logic [15:0] w);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int b = 15; b >= 0; b--) begin
      fb = c[7] ^ w[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return c;
  endfunction

  // ---------------- frame-level model of the two-word instance -------------
  logic [15:0]   m_words [NW];
  logic [NW-1:0] m_fresh, m_acc;
  logic [7:0]    m_err, m_hi, m_lo;
  int            m_pos, m_stall;
  bit            m_done, m_bad, m_en = 1'b0;

  function automatic bit exp_ready();
    return (m_stall == 0) && !m_done && !abort;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) m_words[i] = 16'h0;
      m_fresh = '0; m_acc = '0; m_err = 8'd0; m_hi = 8'd0; m_lo = 8'd0;
      m_pos = 0; m_stall = 0; m_done = 1'b0; m_bad = 1'b0; m_en = 1'b1;
    end else if (abort) begin
      m_pos = 0; m_stall = 0; m_done = 1'b0; m_bad = 1'b0; m_acc = '0;
    end else if (m_done) begin
      m_fresh = m_acc; m_acc = '0; m_bad = 1'b0; m_done = 1'b0;
    end else if (m_stall > 0) begin
      m_stall--;
    end else if (in_valid) begin
      case (m_pos % 3)
        0: begin m_hi = in_data; m_stall = 8; m_pos++; end
        1: begin m_lo = in_data; m_stall = 8; m_pos++; end
        default: begin
          if (in_data == crc_ref({m_hi, m_lo})) begin
            m_words[m_pos/3] = {m_hi, m_lo};
            m_acc[m_pos/3]   = 1'b1;
          end else begin
            m_bad = 1'b1;
            if (m_err != 8'hFF) m_err++;
          end
          if (m_pos == 3*NW-1) begin
            m_done = 1'b1;
            m_pos  = 0;
          end else begin
            m_pos++;
          end
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    #2;
    if (m_en && rst_n) begin
      chk("in_ready",     in_ready,     exp_ready());
      chk("frame_done",   frame_done,   m_done && !abort);
      chk("frame_crc_ok", frame_crc_ok, m_done && !abort && !m_bad);
      chk("word_data",    word_data,    {m_words[1], m_words[0]});
      chk("word_fresh",   word_fresh,   m_fresh);
      chk("crc_err_cnt",  crc_err_cnt,  m_err);
      if (frame_done) begin
        n_done++;
        last_ok = frame_crc_ok;
      end
      if (frame_done2) begin
        n_done2++;
        last_ok2 = frame_crc_ok2;
      end
    end
  end

  // ---------------- drivers (called at a negedge) --------------------------
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    #1;
    while (!in_ready) begin
      @(negedge clk); #1; n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: byte %h got no in_ready, required within 50 cycles", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic send2(input logic [7:0] b);
    int n = 0;
    in_valid2 = 1'b1; in_data2 = b;
    #1;
    while (!in_ready2) begin
      @(negedge clk); #1; n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL send2_timeout: byte %h got no in_ready, required within 50 cycles", b);
        in_valid2 = 1'b0;
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send(f[8*i +: 8]);
  endtask

  task automatic send_frame2(input logic [23:0] f);
    for (int i = 2; i >= 0; i--) send2(f[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Count cycles with in_ready low right after a data byte was accepted
  task automatic stall_len(output int cnt);
    cnt = 0;
    #1;
    while (!in_ready && cnt < 20) begin
      cnt++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s;
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    abort2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_word_data",  word_data,   32'h0);
    chk("rst_word_fresh", word_fresh,  2'b00);
    chk("rst_err_cnt",    crc_err_cnt, 8'd0);
    chk("rst_frame_done", frame_done,  1'b0);
    chk("rst_in_ready",   in_ready,    1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: clean frame
    base = n_done;
    send_frame(48'hBE_EF_92_00_00_81);
    idle(3);
    chk("t1_word_data",  word_data,   32'h0000_BEEF);
    chk("t1_word_fresh", word_fresh,  2'b11);
    chk("t1_crc_ok",     last_ok,     1'b1);
    chk("t1_done_cnt",   n_done - base, 1);
    chk("t1_err_cnt",    crc_err_cnt, 8'd0);

    // 2: word 0 CRC corrupted
    base = n_done;
    send_frame(48'hBE_EF_93_00_00_81);
    idle(3);
    chk("t2_word_data",  word_data,   32'h0000_BEEF);
    chk("t2_word_fresh", word_fresh,  2'b10);
    chk("t2_crc_ok",     last_ok,     1'b0);
    chk("t2_done_cnt",   n_done - base, 1);
    chk("t2_err_cnt",    crc_err_cnt, 8'd1);

    // 3: in_valid held high across the whole frame
    base = n_done;
    send(8'h00); stall_len(s); chk("t3_stall_b0", s, 8);
    send(8'h00); stall_len(s); chk("t3_stall_b1", s, 8);
    send(8'h81);
    send(8'hBE); stall_len(s); chk("t3_stall_b3", s, 8);
    send(8'hEF); stall_len(s); chk("t3_stall_b4", s, 8);
    send(8'h92);
    idle(3);
    chk("t3_word_data",  word_data,   32'hBEEF_0000);
    chk("t3_word_fresh", word_fresh,  2'b11);
    chk("t3_done_cnt",   n_done - base, 1);

    // 4: abort during the shift after the second byte, then a clean frame
    base = n_done;
    send(8'h11);
    send(8'h22);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    send_frame(48'hBE_EF_92_00_00_81);
    idle(3);
    chk("t4_word_data",  word_data,   32'h0000_BEEF);
    chk("t4_word_fresh", word_fresh,  2'b11);
    chk("t4_done_cnt",   n_done - base, 1);
    chk("t4_err_cnt",    crc_err_cnt, 8'd1);

    // 5: reset mid-frame
    send(8'hBE); send(8'hEF); send(8'h93); send(8'h00);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_word_data",  word_data,   32'h0);
    chk("t5_word_fresh", word_fresh,  2'b00);
    chk("t5_err_cnt",    crc_err_cnt, 8'd0);
    chk("t5_in_ready",   in_ready,    1'b1);
    chk("t5_frame_done", frame_done,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(48'hBE_EF_92_00_00_81);
    idle(3);
    chk("t5_post_word_data",  word_data,  32'h0000_BEEF);
    chk("t5_post_word_fresh", word_fresh, 2'b11);

    // 6: one-word instance, good frame then 260 bad frames
    base = n_done2;
    send_frame2(24'hBE_EF_92);
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_word_data",  word_data2,   16'hBEEF);
    chk("t6_word_fresh", word_fresh2,  1'b1);
    chk("t6_crc_ok",     last_ok2,     1'b1);
    chk("t6_done_cnt",   n_done2 - base, 1);
    for (int k = 0; k < 100; k++) send_frame2(24'hBE_EF_00);
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_100",    crc_err_cnt2, 8'd100);
    chk("t6_fresh_bad",  word_fresh2,  1'b0);
    chk("t6_crc_ok_bad", last_ok2,     1'b0);
    for (int k = 0; k < 155; k++) send_frame2(24'hBE_EF_00);
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_255",    crc_err_cnt2, 8'd255);
    for (int k = 0; k < 5; k++) send_frame2(24'hBE_EF_00);
    in_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_sat",    crc_err_cnt2, 8'd255);
    chk("t6_word_keep",  word_data2,   16'hBEEF);
    chk("t6_done_total", n_done2 - base, 261);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
